mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and select controller for an 8:1 one-bit multiplexer datapath.
- Eight requesters compete for the shared mux output.
- The block grants one requester at a time and drives the 3-bit select.
- It routes data_in[sel] to y, enforcing fair rotation plus a maximum hold time per grant.

---
 rtl/mux8_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//   Round-robin arbiter and select controller for an 8:1 one-bit mux.
//   One requester owns the shared output at a time. A grant lasts at most
//   MAX_HOLD cycles. Every grant is followed by a single idle bubble.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles a grant may be held (2..256)
//   CNT_W     hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit k = requester k
//   rel        current owner finished; ends the grant this cycle
//   data_in    mux data inputs, bit k belongs to requester k
//   gnt        one-hot grant (registered)
//   gnt_valid  any grant active (registered)
//   sel        binary index of the granted requester (registered)
//   y          data_in[sel] while gnt_valid, else 0
//   timeout    one-cycle pulse when a grant is revoked by hold expiry
// ---------------------------------------------------------------------------

// Per-requester output gate. Because gnt is one-hot or zero, OR-ing the
// gated lanes selects data_in[sel] while a grant is active and 0 otherwise.
module mux8_rr_lane (
  input  logic gnt,
  input  logic data,
  output logic y
);
  assign y = gnt & data;
endmodule

module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  input  logic [7:0] data_in,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] sel,
  output logic       y,
  output logic       timeout
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   gnt_q, gnt_d;
  logic                   gnt_valid_q, gnt_valid_d;
  logic [2:0]             sel_q, sel_d;
  logic                   timeout_q, timeout_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic                   found;
  logic [2:0]             win;
  logic [2:0]             scan_idx;
  logic                   hold_max;
  logic                   end_grant;
  logic                   timeout_hit;
  logic [NUM_LANES-1:0]   lane_y;

  // Winner search: first set request starting at ptr, wrapping mod 8.
  // The 3-bit index addition provides the wrap for free.
  always_comb begin
    found    = 1'b0;
    win      = ptr_q;
    scan_idx = ptr_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // Grant termination causes. timeout only flags pure hold expiry.
  assign hold_max    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign end_grant   = rel | ~req[sel_q] | hold_max;
  assign timeout_hit = hold_max & ~rel & req[sel_q];

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      sel_q       <= 3'd0;
      timeout_q   <= 1'b0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      sel_q       <= sel_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)     state_d = GRANT;
      GRANT:   if (end_grant) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic. sel holds its last value while idle.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    sel_d       = sel_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = 8'd1 << win;
          sel_d       = win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (end_grant) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = sel_q + 3'd1;
          timeout_d   = timeout_hit;
        end else begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    mux8_rr_lane u_lane (
      .gnt  (gnt_q[k]),
      .data (data_in[k]),
      .y    (lane_y[k])
    );
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign sel       = sel_q;
  assign timeout   = timeout_q;
  assign y         = |lane_y;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter. The driver applies one vector per
// cycle on the falling edge and queues the hand-computed outputs expected
// after the next rising edge; the monitor pops and compares just after it.
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] sel;
  logic       y;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] sel;
    logic       to;
    logic       y;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .data_in   (data_in),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel),
    .y         (y),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, n_cyc, act, exp);
    end
  endtask

  // Apply one vector and queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] r, input logic rl, input logic [7:0] d,
                      input logic v, input logic [2:0] s, input logic to);
    exp_t e;
    @(negedge clk);
    req     = r;
    rel     = rl;
    data_in = d;
    e.gnt = v ? (8'd1 << s) : 8'd0;
    e.vld = v;
    e.sel = s;
    e.to  = to;
    e.y   = v ? d[s] : 1'b0;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("gnt",       gnt,             e.gnt);
        chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.vld});
        chk("sel",       {5'd0, sel},       {5'd0, e.sel});
        chk("timeout",   {7'd0, timeout},   {7'd0, e.to});
        chk("y",         {7'd0, y},         {7'd0, e.y});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_check(input string tag);
    chk({tag, "_gnt"},   gnt,               8'h00);
    chk({tag, "_vld"},   {7'd0, gnt_valid}, 8'h00);
    chk({tag, "_sel"},   {5'd0, sel},       8'h00);
    chk({tag, "_to"},    {7'd0, timeout},   8'h00);
    chk({tag, "_y"},     {7'd0, y},         8'h00);
  endtask

  logic [7:0] dtab [3];

  initial begin
    dtab[0] = 8'hCC; dtab[1] = 8'h33; dtab[2] = 8'h56;
    rst_n = 1'b0; req = 8'h00; rel = 1'b0; data_in = 8'hFF;
    #1;
    reset_check("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 0, 8'hFF, 0, 3'd0, 0);            // idle, no requests

    // Rotation 0..7,0 with release one cycle after each grant; data varies.
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 0, dtab[k % 3], 1, 3'(k % 8), 0);
      step(8'hFF, 1, dtab[k % 3], 0, 3'(k % 8), 0);
    end
    // ptr now 1: grant requester 1, hold once, then reset mid-grant.
    step(8'hFF, 0, 8'hFF, 1, 3'd1, 0);
    step(8'hFF, 0, 8'hFF, 1, 3'd1, 0);
    @(negedge clk);
    rst_n = 1'b0; req = 8'h00; data_in = 8'hFF;
    #1;
    reset_check("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 0, 8'hFF, 1, 3'd0, 0);            // restarts from ptr 0
    step(8'hFF, 1, 8'hFF, 0, 3'd0, 0);

    // Pointer wrap: grant 7, release, then 0 wins over 7.
    step(8'h80, 0, 8'h80, 1, 3'd7, 0);
    step(8'h81, 1, 8'h80, 0, 3'd7, 0);
    step(8'h81, 0, 8'h81, 1, 3'd0, 0);
    step(8'h81, 1, 8'h81, 0, 3'd0, 0);

    // Timeout: 16 granted cycles, timeout pulse, re-grant, then req drop.
    for (int i = 0; i < 16; i++) step(8'h04, 0, 8'h56, 1, 3'd2, 0);
    step(8'h04, 0, 8'h56, 0, 3'd2, 1);
    step(8'h04, 0, 8'h56, 1, 3'd2, 0);
    step(8'h00, 0, 8'h56, 0, 3'd2, 0);            // req dropped: no timeout

    // Release coinciding with hold expiry: no timeout.
    for (int i = 0; i < 16; i++) step(8'h04, 0, 8'h33, 1, 3'd2, 0);
    step(8'h04, 1, 8'h33, 0, 3'd2, 0);

    // Release while idle is ignored.
    step(8'h00, 1, 8'hCC, 0, 3'd2, 0);
    step(8'h08, 1, 8'hCC, 1, 3'd3, 0);
    step(8'h08, 1, 8'hCC, 0, 3'd3, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
